// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit port: register offsets, STATUS bit
// positions, FSM state encoding and the divisor clamp helper.
package uart_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // STATUS bit positions; FIFO count occupies [ST_CNT_LSB +: FIFO_AW+1]
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  // Transmit FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A divisor of 0 would give a zero-length bit; store 1 instead.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_port_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, resetb     clock, asynchronous active-low reset (clears pointers/count)
//   push, wdata     write strobe and data; ignored when full
//   pop             read strobe; ignored when empty
//   rdata           head entry, valid whenever !empty
//   count           occupancy 0..2**AW
//   full, empty     occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter on the core I/O bus.
// Ports:
//   clk, resetb       clock, asynchronous active-low reset
//   io_addr           register address; BASE_ADDR..BASE_ADDR+3 decoded
//   io_en, io_we      one-cycle access strobe and write qualifier
//   io_data_write     write data
//   io_data_read      registered read data, 0 when no read hit last cycle
//   tx                serial output, idle high, driven from a flop
//   irq_tx_empty      level interrupt: irq_en & FIFO empty & FSM idle
module uart_tx_port
  import uart_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'h10,
  parameter int unsigned FIFO_AW     = 3,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        tx,
  output logic        irq_tx_empty
);

  localparam int unsigned CW = FIFO_AW + 1;

  // Bus decode
  logic [7:0] off;
  logic [1:0] reg_off;
  logic       sel, wr, rd, push_req;

  assign off      = io_addr - BASE_ADDR;
  assign sel      = io_en & (off[7:2] == 6'd0);
  assign reg_off  = off[1:0];
  assign wr       = sel & io_we;
  assign rd       = sel & ~io_we;
  assign push_req = wr & (reg_off == OFF_TXDATA);

  logic unused_wdata;
  assign unused_wdata = ^io_data_write[31:16];

  // FIFO
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count, count_next;

  // Fullness is taken before any same-cycle pop.
  assign fifo_push = push_req & ~fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (fifo_push),
    .wdata  (io_data_write[7:0]),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  // Control/status registers
  logic [15:0] div_q, div_d;
  logic        ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] status;

  // Transmit datapath
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reload_q, reload_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;

  always_comb begin
    div_d  = div_q;
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if (wr) begin
      unique case (reg_off)
        OFF_STATUS: if (io_data_write[ST_OVF]) ovf_d = 1'b0;
        OFF_DIV:    div_d  = clamp_div(io_data_write[15:0]);
        OFF_CTRL:   ctrl_d = io_data_write[0];
        default:    ;
      endcase
    end
  end

  always_comb begin
    status                     = '0;
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_BUSY]            = (state_q != S_IDLE);
    status[ST_OVF]             = ovf_q;
    status[ST_CNT_LSB +: CW]   = fifo_count;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (reg_off)
        OFF_STATUS: rdata_d = status;
        OFF_DIV:    rdata_d = {16'h0, div_q};
        OFF_CTRL:   rdata_d = {31'h0, ctrl_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  // Bit timer counts down from DIV-1; a bit ends when it reaches 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_rdata;
          reload_d  = div_q;
          cnt_d     = div_q - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = reload_q - 16'd1;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = reload_q - 16'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx and irq are computed from next-state values so the flops line up with the FSM.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = ctrl_d & (count_next == '0) & (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_q     <= DEFAULT_DIV;
      ctrl_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  assign io_data_read = rdata_q;
  assign tx           = tx_q;
  assign irq_tx_empty = irq_q;

endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;

  localparam logic [7:0] BASE   = 8'h10;
  localparam logic [7:0] A_TX   = BASE + 8'd0;
  localparam logic [7:0] A_STAT = BASE + 8'd1;
  localparam logic [7:0] A_DIV  = BASE + 8'd2;
  localparam logic [7:0] A_CTRL = BASE + 8'd3;

  logic        clk = 1'b0;
  logic        resetb;
  logic [7:0]  io_addr;
  logic        io_en, io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic        tx, irq_tx_empty;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  uart_tx_port #(
    .BASE_ADDR   (8'h10),
    .FIFO_AW     (3),
    .DEFAULT_DIV (16'd104)
  ) dut (
    .clk           (clk),
    .resetb        (resetb),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .tx            (tx),
    .irq_tx_empty  (irq_tx_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus helpers: called at posedge+1, return at posedge+1 of the following cycle.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
    @(posedge clk); #1;
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    io_en = 1'b1; io_we = 1'b0; io_addr = a;
    @(posedge clk); #1;
    io_en = 1'b0;
    d = io_data_read;
  endtask

  // Waits (bounded) for a start bit, then samples the first cycle of every bit.
  task automatic rx_frame(input int div, output logic [7:0] b, output int start,
                          output bit ok);
    int waited = 0;
    ok = 1'b0; b = 8'h00; start = 0;
    while (tx !== 1'b0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (tx !== 1'b0) return;
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (div) begin @(posedge clk); #1; end
      b[i] = tx;
    end
    repeat (div) begin @(posedge clk); #1; end
    ok = (tx === 1'b1);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    n_chk++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_chk++; if (irq_tx_empty !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq_tx_empty);
    else n_pass++;
    n_chk++; if (io_data_read !== 32'h0) $display("FAIL reset_rdata: got %h want 0", io_data_read);
    else n_pass++;
    resetb = 1'b1;
    @(posedge clk); #1;
    bus_read(A_STAT, d);
    n_chk++; if (d !== 32'h2) $display("FAIL reset_status: got %h want 00000002", d); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (io_data_read !== 32'h0) $display("FAIL rdata_idle: got %h want 0", io_data_read);
    else n_pass++;
    bus_read(A_DIV, d);
    n_chk++; if (d !== 32'd104) $display("FAIL reset_div: got %0d want 104", d); else n_pass++;
    bus_read(A_CTRL, d);
    n_chk++; if (d !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", d); else n_pass++;
    bus_read(8'h15, d);
    n_chk++; if (d !== 32'h0) $display("FAIL unmapped_15: got %h want 0", d); else n_pass++;
    bus_read(8'h0F, d);
    n_chk++; if (d !== 32'h0) $display("FAIL unmapped_0f: got %h want 0", d); else n_pass++;
    bus_read(A_TX, d);
    n_chk++; if (d !== 32'h0) $display("FAIL txdata_read: got %h want 0", d); else n_pass++;
  endtask

  task automatic test_frame;
    logic [9:0]  frame;
    logic [31:0] d;
    frame = {1'b1, 8'h55, 1'b0};
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'h55);
    // Now in cycle T+1
    n_chk++; if (tx !== 1'b1) $display("FAIL frame_t1: got %b want 1", tx); else n_pass++;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (tx !== frame[c / 4]) $display("FAIL frame_bit c=%0d: got %b want %b", c, tx, frame[c / 4]);
      else n_pass++;
      if (c == 10) begin
        io_en = 1'b1; io_we = 1'b0; io_addr = A_STAT;
      end
      if (c == 11) begin
        io_en = 1'b0;
        n_chk++;
        if (io_data_read !== 32'h6) $display("FAIL frame_busy: got %h want 00000006", io_data_read);
        else n_pass++;
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_chk++; if (tx !== 1'b1) $display("FAIL frame_after c=%0d: got %b want 1", c, tx);
      else n_pass++;
    end
    bus_read(A_STAT, d);
    n_chk++; if (d !== 32'h2) $display("FAIL frame_idle_status: got %h want 00000002", d);
    else n_pass++;
  endtask

  // With DIV=1 a frame takes 10 cycles, so only the first byte is popped during the
  // burst: 8 FIFO slots + 1 popped = 9 bytes accepted, the rest dropped.
  task automatic test_burst(input int n);
    logic [7:0]  exp_q [$];
    logic [31:0] d;
    int          n_exp;
    int          highs;
    n_exp = (n > 9) ? 9 : n;
    bus_write(A_DIV, 32'd1);
    bus_write(A_STAT, 32'h8);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if (i < 9) exp_q.push_back(8'(i));
          bus_write(A_TX, 32'(i));
        end
      end
      begin
        logic [7:0] b, e;
        int st, prev_st;
        bit ok;
        prev_st = 0;
        for (int k = 0; k < n_exp; k++) begin
          rx_frame(1, b, st, ok);
          n_chk++; if (!ok) $display("FAIL burst%0d_frame%0d: stop/start bad, ok=%0d want 1", n, k, ok);
          else n_pass++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_chk++; if (b !== e) $display("FAIL burst%0d_byte%0d: got %h want %h", n, k, b, e);
          else n_pass++;
          if (k > 0) begin
            n_chk++;
            if (st - prev_st != 11) $display("FAIL burst%0d_gap%0d: got %0d want 11", n, k, st - prev_st);
            else n_pass++;
          end
          prev_st = st;
        end
      end
    join
    highs = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tx === 1'b1) highs++;
    end
    n_chk++; if (highs != 20) $display("FAIL burst%0d_extra: idle-high cycles %0d want 20", n, highs);
    else n_pass++;
    n_chk++; if (exp_q.size() != 0) $display("FAIL burst%0d_left: got %0d want 0", n, exp_q.size());
    else n_pass++;
    bus_read(A_STAT, d);
    n_chk++;
    if (d !== ((n > 9) ? 32'hA : 32'h2)) $display("FAIL burst%0d_status: got %h want %h", n, d,
                                                  (n > 9) ? 32'hA : 32'h2);
    else n_pass++;
  endtask

  task automatic test_status_div;
    logic [31:0] d;
    bus_write(A_STAT, 32'h8);
    bus_read(A_STAT, d);
    n_chk++; if (d !== 32'h2) $display("FAIL ovf_clear: got %h want 00000002", d); else n_pass++;
    bus_write(A_DIV, 32'd0);
    bus_read(A_DIV, d);
    n_chk++; if (d !== 32'd1) $display("FAIL div_zero: got %0d want 1", d); else n_pass++;
    bus_write(A_DIV, 32'h0001_0203);
    bus_read(A_DIV, d);
    n_chk++; if (d !== 32'h203) $display("FAIL div_trunc: got %h want 00000203", d); else n_pass++;
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int          bad;
    bus_write(A_DIV, 32'd4);
    n_chk++; if (irq_tx_empty !== 1'b0) $display("FAIL irq_off: got %b want 0", irq_tx_empty);
    else n_pass++;
    bus_write(A_CTRL, 32'h1);
    n_chk++; if (irq_tx_empty !== 1'b1) $display("FAIL irq_on: got %b want 1", irq_tx_empty);
    else n_pass++;
    bus_write(A_TX, 32'hA3);
    // Cycle P+1
    n_chk++; if (irq_tx_empty !== 1'b0) $display("FAIL irq_drop: got %b want 0", irq_tx_empty);
    else n_pass++;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (irq_tx_empty !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL irq_frame: high in %0d cycles want 0", bad); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (irq_tx_empty !== 1'b1) $display("FAIL irq_rise: got %b want 1", irq_tx_empty);
    else n_pass++;
    bus_read(A_CTRL, d);
    n_chk++; if (d !== 32'h1) $display("FAIL ctrl_read: got %h want 00000001", d); else n_pass++;
    bus_write(A_CTRL, 32'h0);
    n_chk++; if (irq_tx_empty !== 1'b0) $display("FAIL irq_disable: got %b want 0", irq_tx_empty);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int          highs;
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    // Cycle T+3; wait into DATA bit 0 of byte 0x00
    repeat (7) begin @(posedge clk); #1; end
    n_chk++; if (tx !== 1'b0) $display("FAIL mid_pre: got %b want 0", tx); else n_pass++;
    #3 resetb = 1'b0;
    #1;
    n_chk++; if (tx !== 1'b1) $display("FAIL mid_async_tx: got %b want 1", tx); else n_pass++;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    @(posedge clk); #1;
    highs = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tx === 1'b1) highs++;
    end
    n_chk++; if (highs != 20) $display("FAIL mid_flushed: idle-high cycles %0d want 20", highs);
    else n_pass++;
    bus_read(A_STAT, d);
    n_chk++; if (d !== 32'h2) $display("FAIL mid_status: got %h want 00000002", d); else n_pass++;
    bus_read(A_DIV, d);
    n_chk++; if (d !== 32'd104) $display("FAIL mid_div: got %0d want 104", d); else n_pass++;
  endtask

  initial begin
    resetb = 1'b0; io_en = 1'b0; io_we = 1'b0; io_addr = 8'h0; io_data_write = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_frame;
    test_burst(9);
    test_burst(10);
    test_status_div;
    test_irq;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
